// File: rtl/twos_to_signmag_serial_if.sv
// Operand/result handshake bundle for twos_to_signmag_serial.
// The slave side is the decoder; the master side is the source/consumer.
interface twos_to_signmag_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic [WIDTH-1:0] out_signmag;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sign,
        input  out_mag,
        input  out_signmag,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sign,
        output out_mag,
        output out_signmag,
        output out_ovf
    );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign/magnitude decoder (LSB-first copy-until-first-one-then-invert).
// Optional SIGNMAG_FASTPATH_EN: non-negative operands skip the shift phase (IDLE->DONE in one edge).
module twos_to_signmag_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic                          CLK,
    input  logic                          RESET,
    twos_to_signmag_serial_if.slave       bus,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   sr_q,      sr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               sign_q,    sign_d;
    logic               seen_q,    seen_d;
    logic [WIDTH-1:0]   mag_q,     mag_d;
    logic [WIDTH-1:0]   signmag_q, signmag_d;
    logic               ovf_q,     ovf_d;

    logic               bit_c;
    logic               out_bit_c;

    // Negative operands: pass bits up to and including the first one, invert after it
    assign bit_c     = sr_q[0];
    assign out_bit_c = (sign_q && seen_q) ? ~bit_c : bit_c;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        seen_d    = seen_q;
        mag_d     = mag_q;
        signmag_d = signmag_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = bus.in_data;
                    sign_d  = bus.in_data[WIDTH-1];
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    mag_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SIGNMAG_FASTPATH_EN
                    // A non-negative operand is already its own magnitude
                    if (!bus.in_data[WIDTH-1]) begin
                        mag_d     = bus.in_data;
                        signmag_d = bus.in_data;
                        ovf_d     = 1'b0;
                        state_d   = ST_DONE;
                    end
`endif
                end
            end

            ST_SHIFT: begin
                sr_d   = {1'b0, sr_q[WIDTH-1:1]};
                seen_d = seen_q | bit_c;
                mag_d  = {out_bit_c, mag_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    // Only the most negative value yields a magnitude with its MSB set
                    ovf_d     = sign_q & mag_d[WIDTH-1];
                    signmag_d = ovf_d ? {WIDTH{1'b1}} : {sign_q, mag_d[WIDTH-2:0]};
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            seen_q    <= 1'b0;
            mag_q     <= '0;
            signmag_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            seen_q    <= seen_d;
            mag_q     <= mag_d;
            signmag_q <= signmag_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign busy            = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.out_sign    = sign_q;
    assign bus.out_mag     = mag_q;
    assign bus.out_signmag = signmag_q;
    assign bus.out_ovf     = ovf_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Self-checking bench for twos_to_signmag_serial: directed table, reset corners, random traffic vs. arithmetic model.
module tb_twos_to_signmag_serial;

    localparam int unsigned W = 8;

    logic CLK;
    logic RESET;
    logic busy;

    twos_to_signmag_serial_if #(.WIDTH(W)) bus ();

    twos_to_signmag_serial #(.WIDTH(W), .CNT_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .busy  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int accepts  = 0;
    int ops      = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         sign;
        logic [W-1:0] mag;
        logic [W-1:0] signmag;
        logic         ovf;
        int           stall;
    } vec_t;

    always @(negedge CLK) begin
        if (!RESET && bus.in_valid && bus.in_ready) accepts++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on the operand value
    function automatic void model(input logic [W-1:0] d, output logic s, output logic [W-1:0] m,
                                  output logic [W-1:0] sm, output logic o);
        int v;
        int a;
        v  = int'($signed(d));
        s  = (v < 0);
        a  = (v < 0) ? -v : v;
        m  = W'(a);
        o  = (a == (1 << (W - 1)));
        sm = o ? {W{1'b1}} : W'((int'(s) << (W - 1)) | (a & ((1 << (W - 1)) - 1)));
    endfunction

    task automatic run_op(input logic [W-1:0] d, input logic es, input logic [W-1:0] em,
                          input logic [W-1:0] esm, input logic eo, input int stall, input bit noisy);
        int n;
        int exp_lat;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready before accept", 32'(bus.in_ready), 32'd1);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        ops++;
        bus.in_valid = 1'b0;
        exp_lat = W;
`ifdef SIGNMAG_FASTPATH_EN
        if (!d[W-1]) exp_lat = 0;
`endif
        n = 0;
        while (!bus.out_valid && n < 100) begin
            if (noisy) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_data   = W'($urandom);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            step();
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
        check("sign", 32'(bus.out_sign), 32'(es));
        check("mag", 32'(bus.out_mag), 32'(em));
        check("signmag", 32'(bus.out_signmag), 32'(esm));
        check("ovf", 32'(bus.out_ovf), 32'(eo));
        check("in_ready in done", 32'(bus.in_ready), 32'd0);
        check("busy in done", 32'(busy), 32'd1);
        for (int i = 0; i < stall; i++) begin
            step();
            check("held valid", 32'(bus.out_valid), 32'd1);
            check("held in_ready", 32'(bus.in_ready), 32'd0);
            check("held mag", 32'(bus.out_mag), 32'(em));
            check("held signmag", 32'(bus.out_signmag), 32'(esm));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle in_ready", 32'(bus.in_ready), 32'd1);
        check("idle out_valid", 32'(bus.out_valid), 32'd0);
        check("idle mag kept", 32'(bus.out_mag), 32'(em));
    endtask

    vec_t vecs[8];

    initial begin
        logic         s;
        logic         o;
        logic [W-1:0] m;
        logic [W-1:0] sm;
        logic [W-1:0] d;

        vecs[0] = '{data: 8'h05, sign: 1'b0, mag: 8'h05, signmag: 8'h05, ovf: 1'b0, stall: 0};
        vecs[1] = '{data: 8'hFB, sign: 1'b1, mag: 8'h05, signmag: 8'h85, ovf: 1'b0, stall: 0};
        vecs[2] = '{data: 8'hFF, sign: 1'b1, mag: 8'h01, signmag: 8'h81, ovf: 1'b0, stall: 1};
        vecs[3] = '{data: 8'h80, sign: 1'b1, mag: 8'h80, signmag: 8'hFF, ovf: 1'b1, stall: 0};
        vecs[4] = '{data: 8'h00, sign: 1'b0, mag: 8'h00, signmag: 8'h00, ovf: 1'b0, stall: 0};
        vecs[5] = '{data: 8'h9C, sign: 1'b1, mag: 8'h64, signmag: 8'hE4, ovf: 1'b0, stall: 5};
        vecs[6] = '{data: 8'h7F, sign: 1'b0, mag: 8'h7F, signmag: 8'h7F, ovf: 1'b0, stall: 2};
        vecs[7] = '{data: 8'h81, sign: 1'b1, mag: 8'h7F, signmag: 8'hFF, ovf: 1'b0, stall: 0};

        RESET         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst mag", 32'(bus.out_mag), 32'd0);
        check("rst signmag", 32'(bus.out_signmag), 32'd0);
        check("rst sign", 32'(bus.out_sign), 32'd0);
        check("rst ovf", 32'(bus.out_ovf), 32'd0);
        RESET = 1'b0;
        step();

        // Reset and in_valid on the same edge: reset wins
        bus.in_data  = 8'h33;
        bus.in_valid = 1'b1;
        RESET        = 1'b1;
        step();
        RESET        = 1'b0;
        bus.in_valid = 1'b0;
        check("rst+valid in_ready", 32'(bus.in_ready), 32'd1);
        check("rst+valid busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].data, vecs[i].sign, vecs[i].mag, vecs[i].signmag, vecs[i].ovf,
                   vecs[i].stall, 1'b0);
        end

        // Reset lands on the 4th shift edge of 0xC3
        bus.in_data  = 8'hC3;
        bus.in_valid = 1'b1;
        step();
        ops++;
        bus.in_valid = 1'b0;
        repeat (3) step();
`ifndef SIGNMAG_FASTPATH_EN
        check("mid-shift busy", 32'(busy), 32'd1);
`endif
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort mag", 32'(bus.out_mag), 32'd0);
        check("abort signmag", 32'(bus.out_signmag), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        run_op(8'h7F, 1'b0, 8'h7F, 8'h7F, 1'b0, 0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            d = W'($urandom);
            model(d, s, m, sm, o);
            run_op(d, s, m, sm, o, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        check("accept count", 32'(accepts), 32'(ops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/twos_to_signmag_serial.md
Name: twos_to_signmag_serial

Overview:
- Bit-serial decoder that takes an 8-bit two's-complement operand and returns sign, magnitude and sign-magnitude forms.
- It is the inverse-direction companion of the combinational negator in the ALU datapath.
- Sits between the register file read port and the display/debug path. It processes one operand at a time using a valid/ready handshake on both sides.
- Magnitude is built LSB-first with the copy-until-first-one-then-invert rule, one bit per clock.

Parameters:
- WIDTH, 8, operand width in bits (min 2).
- CNT_W, 3, bit-counter width, must equal ceil(log2(WIDTH)).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sign  output  1  1 = operand negative.
- out_mag  output  WIDTH  unsigned magnitude |in_data|.
- out_signmag  output  WIDTH  {sign, mag[WIDTH-2:0]}; saturated on overflow.
- out_ovf  output  1  operand was the most negative value (-2^(WIDTH-1)).
- busy  output  1  state is SHIFT or DONE.

Behaviour:
- Reset and interface rules:
  - Single clock domain. Reset is synchronous, active-high: RESET sampled high at a rising CLK edge forces the reset state.
  - Reset values: state=IDLE, counter=0, all result registers 0, out_valid=0, out_sign=0, out_mag=0, out_signmag=0, out_ovf=0, busy=0. in_ready=1 in the first cycle after reset.
  - in_ready = (state==IDLE); out_valid = (state==DONE); both decoded combinationally from registered state only.
- States:
  - IDLE: operand accepted on the edge where in_valid & in_ready. That edge latches in_data into shift register sr, sets sign=in_data[WIDTH-1], clears seen_one, counter=0, clears out_mag, and goes to SHIFT.
  - SHIFT: each edge processes bit b=sr[0].
    - If sign=0, the output bit is b; otherwise it is (seen_one ? ~b : b).
    - seen_one |= b.
    - The output bit is shifted into out_mag from the MSB side (out_mag <= {bit, out_mag[WIDTH-1:1]}); sr shifts right.
    - counter increments. On the edge where counter==WIDTH-1, go to DONE and register out_ovf and out_signmag from the final magnitude.
  - DONE: results held stable while out_ready=0. The edge with out_ready=1 goes to IDLE; result registers keep their values until the next accept.
- Latency: accept at edge T; out_valid high in the cycle after edge T+WIDTH (WIDTH+1 edges). Throughput: one operand per WIDTH+2 cycles minimum. No overlap: a new operand is never accepted in DONE.
- Arithmetic and boundary values:
  - Non-negative: out_mag = in_data, out_signmag = in_data, out_ovf=0.
  - Negative: out_mag = (~in_data + 1) mod 2^WIDTH.
  - Zero → sign 0, mag 0, signmag 0. Negative zero is never produced.
  - Most negative (0x80 for WIDTH=8): out_mag=0x80, out_ovf=1, out_signmag saturates to {1, all ones}=0xFF.
- Other boundary conditions:
  - in_valid while not IDLE is ignored; the source must hold it.
  - out_ready high outside DONE has no effect.
  - RESET mid-SHIFT or in DONE aborts the operation: the in-flight operand is dropped and outputs return to reset values on that edge.
  - RESET and in_valid together: reset wins, no accept.

Optional Feature:
- Macro SIGNMAG_FASTPATH_EN.
- Defined: a non-negative operand at accept goes directly IDLE→DONE with out_mag=in_data registered on the accept edge (out_valid the following cycle, latency 1). Negative operands use SHIFT unchanged.
- Undefined: all operands take the uniform WIDTH+1-edge SHIFT path.

Test Plan:
- Reset then accept in_data=0x05 with out_ready=1 → out_valid after 9 edges; sign=0, mag=0x05, signmag=0x05, ovf=0 (1 edge with SIGNMAG_FASTPATH_EN).
- in_data=0xFB (-5) → sign=1, mag=0x05, signmag=0x85, ovf=0. Then 0xFF → mag=0x01, signmag=0x81.
- in_data=0x80 → sign=1, mag=0x80, ovf=1, signmag=0xFF. Then in_data=0x00 → all zero, ovf=0.
- Backpressure: in_data=0x9C (-100), out_ready low 5 cycles in DONE → outputs held at mag=0x64, signmag=0xE4, in_ready=0 throughout. out_ready high → IDLE next edge.
- RESET asserted on 4th SHIFT edge of 0xC3 → next cycle state IDLE, in_ready=1, out_valid=0, mag=0. Follow-up 0x7F → mag=0x7F.
- Random 1000 operands with random out_ready stalls → every result matches the reference negation model; no accepts outside IDLE.
